// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant and a stall watchdog.
// The granted master is muxed combinationally onto the slave port and keeps it until it drops cyc.
module wishbone_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 24,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [7:0]            m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    output logic [7:0]            m0_dat_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [7:0]            m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic [7:0]            m1_dat_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [7:0]            s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    input  logic [7:0]            s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                   state;
    logic                     last;
    logic [TIMEOUT_WIDTH-1:0] count;

    logic                     granted;
    logic                     sel1;
    logic                     sel_cyc;
    logic                     sel_stb;
    logic                     sel_we;
    logic [ADDR_WIDTH-1:0]    sel_adr;
    logic [7:0]               sel_dat;
    logic                     resp;
    logic                     timeout;

    // Grant FSM; last remembers the most recently released master for round robin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state <= last ? GNT0 : GNT1;
                    end else if (m0_cyc_i) begin
                        state <= GNT0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall watchdog: counts granted cycles with stb high and no slave response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (!granted || !sel_stb || resp || timeout) begin
            count <= '0;
        end else begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    // Master select for the slave-side mux.
    always_comb begin
        granted = (state == GNT0) || (state == GNT1);
        sel1    = (state == GNT1);
        sel_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
        sel_stb = sel1 ? m1_stb_i : m0_stb_i;
        sel_we  = sel1 ? m1_we_i  : m0_we_i;
        sel_adr = sel1 ? m1_adr_i : m0_adr_i;
        sel_dat = sel1 ? m1_dat_i : m0_dat_i;
        resp    = s_ack_i || s_err_i || s_rty_i;
        timeout = granted && (&count) && !resp;
    end

    // Slave port: zero while idle, cyc/stb suppressed in the timeout cycle.
    always_comb begin
        s_cyc_o = granted && sel_cyc && !timeout;
        s_stb_o = granted && sel_stb && !timeout;
        s_we_o  = granted && sel_we;
        s_adr_o = granted ? sel_adr : '0;
        s_dat_o = granted ? sel_dat : 8'h00;
    end

    // Responses go only to the granted master; read data is broadcast.
    always_comb begin
        m0_ack_o = (state == GNT0) && s_ack_i;
        m0_err_o = (state == GNT0) && (s_err_i || timeout);
        m0_rty_o = (state == GNT0) && s_rty_i;
        m1_ack_o = (state == GNT1) && s_ack_i;
        m1_err_o = (state == GNT1) && (s_err_i || timeout);
        m1_rty_o = (state == GNT1) && s_rty_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

endmodule
